// File: rtl/mem_dma.sv
// Word-oriented memory DMA: copies a block (read/write pairs) or fills a block with a pattern.
// Single memory port, one access per clock, ascending addresses with modulo-2^ADDR_W wrap.
//
// state | meaning
// IDLE  | waiting for start, memory port parked at zero
// READ  | copy only: fetch source word src+i into data register
// WRITE | store word at dst+i, advance i
// DONE  | one-cycle completion pulse
module mem_dma #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   src_q, src_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                we_q, we_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src;
                    dst_d  = dst;
                    len_d  = len;
                    fill_d = fill_val;
                    idx_d  = '0;
                    if (len == '0)
                        state_d = S_DONE;
                    else
                        state_d = mode ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                data_d  = mem_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == len_q - ADDR_W'(1))
                    state_d = S_DONE;
                else
                    state_d = mode_q ? S_WRITE : S_READ;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status strobes come straight from flops so they cannot glitch on state decode.
    always_comb begin
        busy_d = (state_d == S_READ) || (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
        we_d   = (state_d == S_WRITE);
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign mem_we = we_q;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_READ: begin
                mem_addr = src_q + idx_q;
            end
            S_WRITE: begin
                mem_addr  = dst_q + idx_q;
                mem_wdata = mode_q ? fill_q : data_q;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// Bench for mem_dma: sparse memory model on the port, a per-cycle expected-output queue built
// from the transfer rules, and a reference memory that commits only writes that really happened.
module tb_mem_dma;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [AW-1:0] len = '0;
    logic [DW-1:0] fill_val = '0;
    logic          busy, done, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata, mem_wdata;

    mem_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .fill_val  (fill_val),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we)
    );

    always #5 clk = ~clk;

    bit [DW-1:0] mem     [0:65535];
    bit [DW-1:0] ref_mem [0:65535];
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_a = '0;
    logic [DW-1:0] poke_d = '0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (poke_en) mem[poke_a] <= poke_d;
    end

    typedef struct {
        bit          busy;
        bit          done;
        bit          we;
        bit [AW-1:0] addr;
        bit [DW-1:0] wdata;
    } cyc_t;

    cyc_t          exp_q[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            busy_cnt = 0;
    int            done_at = -1;
    logic [AW-1:0] wr_log[$];
    bit            pend_v = 1'b0;
    bit [AW-1:0]   pend_a;
    bit [DW-1:0]   pend_d;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Expected outputs, one entry per cycle after the start edge; copies read through the
    // words already written by this transfer so overlapping copies propagate.
    task automatic push_model(bit m, bit [AW-1:0] s, bit [AW-1:0] d, bit [AW-1:0] l,
                              bit [DW-1:0] f);
        bit [DW-1:0] shadow [bit [AW-1:0]];
        bit [AW-1:0] as_, ad;
        bit [DW-1:0] v;
        for (int i = 0; i < int'(l); i++) begin
            as_ = s + AW'(i);
            ad  = d + AW'(i);
            if (!m) begin
                v = shadow.exists(as_) ? shadow[as_] : ref_mem[as_];
                exp_q.push_back('{busy:1'b1, done:1'b0, we:1'b0, addr:as_, wdata:'0});
            end else begin
                v = f;
            end
            exp_q.push_back('{busy:1'b1, done:1'b0, we:1'b1, addr:ad, wdata:v});
            shadow[ad] = v;
        end
        exp_q.push_back('{busy:1'b0, done:1'b1, we:1'b0, addr:'0, wdata:'0});
    endtask

    initial forever begin
        cyc_t e;
        @(posedge clk);
        if (poke_en) ref_mem[poke_a] = poke_d;
        if (pend_v && rst_n) ref_mem[pend_a] = pend_d;
        pend_v = 1'b0;
        #1;
        cyc++;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{busy:1'b0, done:1'b0, we:1'b0, addr:'0, wdata:'0};
        tests++;
        if ({busy, done, mem_we, mem_addr, mem_wdata} !== {e.busy, e.done, e.we, e.addr, e.wdata}) begin
            fails++;
            $display("FAIL cycle_out cyc=%0d got busy=%b done=%b we=%b addr=%h wdata=%h exp busy=%b done=%b we=%b addr=%h wdata=%h",
                     cyc, busy, done, mem_we, mem_addr, mem_wdata, e.busy, e.done, e.we, e.addr, e.wdata);
        end
        if (e.we) begin
            pend_v = 1'b1;
            pend_a = e.addr;
            pend_d = e.wdata;
        end
        if (done) begin
            done_cnt++;
            done_at = cyc;
        end
        if (busy) busy_cnt++;
        if (mem_we) wr_log.push_back(mem_addr);
    end

    task automatic poke(bit [AW-1:0] a, bit [DW-1:0] d);
        @(negedge clk);
        poke_en = 1'b1;
        poke_a  = a;
        poke_d  = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic run_op(bit m, bit [AW-1:0] s, bit [AW-1:0] d, bit [AW-1:0] l, bit [DW-1:0] f,
                          bit extra_start, bit release_rst, output int s0);
        int          n;
        bit [AW-1:0] a;
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        done_at  = -1;
        wr_log.delete();
        s0 = cyc;
        mode = m; src = s; dst = d; len = l; fill_val = f;
        start = 1'b1;
        push_model(m, s, d, l, f);
        @(negedge clk);
        // Scramble operands (and optionally re-strobe start) to prove they were latched.
        start    = extra_start;
        mode     = ~m;
        src      = AW'($urandom);
        dst      = AW'($urandom);
        len      = AW'($urandom_range(1, 9));
        fill_val = $urandom;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL op_timeout got=%0d_pending exp=0_pending", exp_q.size());
            exp_q.delete();
        end
        for (int i = 0; i < int'(l); i++) begin
            a = d + AW'(i);
            chk("mem_word", mem[a], ref_mem[a]);
        end
    endtask

    initial begin
        #1000000;
        tests++;
        fails++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int          s0;
        bit          m;
        bit [AW-1:0] s, d, l, a;
        bit [DW-1:0] w0;
        int          r;

        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, mem_we, mem_addr, mem_wdata}, 64'd0);

        // Fill of three words, started on the very first edge after reset release.
        run_op(1'b1, 16'h0000, 16'h0010, 16'd3, 32'hDEADBEEF, 1'b0, 1'b1, s0);
        chk("fill_done_cycle", done_at - s0, 64'd4);
        chk("fill_busy_cycles", busy_cnt, 64'd3);
        chk("fill_done_cnt", done_cnt, 64'd1);
        chk("fill_nwr", wr_log.size(), 64'd3);
        chk("fill_addr0", wr_log[0], 64'h0010);
        chk("fill_addr1", wr_log[1], 64'h0011);
        chk("fill_addr2", wr_log[2], 64'h0012);
        chk("fill_mem10", mem[16'h0010], 64'hDEADBEEF);
        chk("fill_mem11", mem[16'h0011], 64'hDEADBEEF);
        chk("fill_mem12", mem[16'h0012], 64'hDEADBEEF);

        // Two-word copy.
        poke(16'h0000, 32'h11111111);
        poke(16'h0001, 32'h22222222);
        run_op(1'b0, 16'h0000, 16'h0100, 16'd2, 32'h0, 1'b0, 1'b0, s0);
        chk("copy_done_cycle", done_at - s0, 64'd5);
        chk("copy_busy_cycles", busy_cnt, 64'd4);
        chk("copy_mem100", mem[16'h0100], 64'h11111111);
        chk("copy_mem101", mem[16'h0101], 64'h22222222);

        // Zero length in both modes.
        for (int k = 0; k < 2; k++) begin
            run_op(k[0], AW'($urandom), AW'($urandom), 16'd0, $urandom, 1'b0, 1'b0, s0);
            chk("zero_done_cycle", done_at - s0, 64'd1);
            chk("zero_busy_cycles", busy_cnt, 64'd0);
            chk("zero_nwr", wr_log.size(), 64'd0);
        end

        // Address wrap with a start pulse while busy.
        run_op(1'b1, 16'h0000, 16'hFFFF, 16'd2, 32'hA5A5A5A5, 1'b1, 1'b0, s0);
        chk("wrap_nwr", wr_log.size(), 64'd2);
        chk("wrap_addr0", wr_log[0], 64'hFFFF);
        chk("wrap_addr1", wr_log[1], 64'h0000);
        chk("wrap_done_cnt", done_cnt, 64'd1);
        chk("wrap_memFFFF", mem[16'hFFFF], 64'hA5A5A5A5);

        // Reset during the second WRITE of a four-word copy.
        w0 = 32'hC0DE0000;
        for (int k = 0; k < 4; k++) poke(16'h0200 + AW'(k), w0 + DW'(k));
        @(negedge clk);
        done_cnt = 0;
        mode = 1'b0; src = 16'h0200; dst = 16'h0300; len = 16'd4; start = 1'b1;
        push_model(1'b0, 16'h0200, 16'h0300, 16'd4, 32'h0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_reset_we", mem_we, 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("reset_async_outs", {busy, done, mem_we, mem_addr, mem_wdata}, 64'd0);
        repeat (2) @(negedge clk);
        chk("abort_done_cnt", done_cnt, 64'd0);
        chk("abort_mem300", mem[16'h0300], 64'hC0DE0000);
        chk("abort_mem301", mem[16'h0301], 64'd0);
        for (int k = 0; k < 4; k++) begin
            a = 16'h0300 + AW'(k);
            chk("abort_mem_ref", mem[a], ref_mem[a]);
        end
        run_op(1'b1, 16'h0000, 16'h0400, 16'd3, 32'h5EED5EED, 1'b0, 1'b1, s0);
        chk("post_reset_fill_done", done_at - s0, 64'd4);
        chk("post_reset_mem402", mem[16'h0402], 64'h5EED5EED);

        // Randomized transfers, including overlapping and wrapping copies.
        for (int t = 0; t < 25; t++) begin
            m = 1'($urandom);
            l = AW'($urandom_range(0, 10));
            s = AW'($urandom);
            r = $urandom_range(0, 3);
            if (r == 1) s = 16'hFFFF - AW'($urandom_range(0, 4));
            d = AW'($urandom);
            if (r == 0 && l > 1) d = s + AW'($urandom_range(1, int'(l) - 1));
            if (!m) begin
                for (int k = 0; k < int'(l); k++) poke(s + AW'(k), $urandom);
            end
            run_op(m, s, d, l, $urandom, 1'($urandom), 1'b0, s0);
            chk("rand_done_cnt", done_cnt, 64'd1);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
